mac_dot_unit: RTL and testbench
===============================

# mac_dot_unit

Parametrised, pipelined multiply-accumulate processing element that computes one length-`len` dot product per `start`. It accepts operand pairs over a valid/ready handshake and forwards accepted operands to its neighbour for systolic chaining. It supports signed or unsigned operands and optional saturating accumulation. It is the next-generation PE for the matrix array and replaces free-running enable-driven accumulation with a self-sequenced start/done protocol.

## Interface

Parameters:
- `DATA_W`, default 8: operand width.
- `ACC_W`, default 32: accumulator width. Must satisfy `ACC_W >= 2*DATA_W`.
- `LEN_W`, default 8: width of the length field. Maximum dot-product length is `2^LEN_W - 1`.
- `SATURATE`, default 1: 1 clamps the accumulator on overflow; 0 lets it wrap.

Ports:
- `clk`, input, 1: the single clock. All logic is on the rising edge.
- `reset`, input, 1: synchronous, active-low reset.
- `start`, input, 1: begins a dot product. Sampled only in IDLE.
- `len`, input, LEN_W: number of products. Captured when `start` is accepted.
- `signed_mode`, input, 1: 1 selects two's-complement operands. Captured when `start` is accepted.
- `in_valid`, input, 1: `a_in`/`b_in` hold a valid pair.
- `in_ready`, output, 1: the unit accepts a pair this cycle.
- `a_in`, `b_in`, input, DATA_W: operands.
- `a_out`, `b_out`, output, DATA_W: registered copy of the last accepted pair.
- `fwd_valid`, output, 1: one-cycle pulse, high the cycle after each accept.
- `acc_out`, output, ACC_W: running or final accumulator value.
- `busy`, output, 1: high in RUN, DRAIN and DONE.
- `done`, output, 1: one-cycle pulse when `acc_out` is final.
- `ovf`, output, 1: sticky overflow flag for the current dot product.

## Operation

- Reset (`reset`=0 at a rising edge): state goes to IDLE. `in_ready`, `busy`, `done`, `fwd_valid`, `ovf`, `a_out`, `b_out`, `acc_out` and all pipeline valids are cleared to 0. In-flight products are discarded and no `done` is produced. This applies in any state.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - **IDLE:** `in_ready`=0. On `start`=1:
    - capture `len` into the down-counter and capture `signed_mode`;
    - clear `acc_out` and `ovf`;
    - go to DONE if `len`==0, otherwise go to RUN.
  - **RUN:** `in_ready`=1. An accept occurs when `in_valid` and `in_ready` are both high. Each accept:
    - loads `a_out`/`b_out`;
    - decrements the counter;
    - marks stage-1 valid.
    - An accept with counter==1 moves the FSM to DRAIN. Cycles with `in_valid`=0 are bubbles and are not counted.
  - **DRAIN:** `in_ready`=0. Stays for exactly 2 cycles while the multiply and accumulate stages empty, then moves to DONE.
  - **DONE:** `done`=1 for one cycle, then the FSM moves to IDLE.
- `start` outside IDLE is ignored. `start` and `reset` low together: reset wins.
- Pipeline:
  - stage 1: operand registers `a_out`/`b_out`;
  - stage 2: product register, 2*DATA_W bits, loaded when stage-1 is valid;
  - stage 3: the accumulator adds the product when stage-2 is valid.
- Arithmetic:
  - If `signed_mode`=1, operands are sign-extended and the signed product is sign-extended to ACC_W. Otherwise both are zero-extended.
  - Overflow is detected on the ACC_W+1-bit sum.
  - `SATURATE`=1: clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1) in signed mode, or to 2^ACC_W-1 in unsigned mode.
  - `SATURATE`=0: wrap modulo 2^ACC_W.
  - In both cases `ovf` sets and stays set until the next accepted `start`.
- `acc_out` and `ovf` hold their values after DONE until the next accepted `start`.

## Timing

- `start` sampled at edge e0:
  - with `len`>0, `in_ready` is high from the cycle after e0;
  - with `len`=0, `done` is high in the cycle after e0 and `acc_out`=0.
- A pair accepted at edge t:
  - `a_out`/`b_out` and `fwd_valid` are valid from t;
  - the product is registered at t+1;
  - `acc_out` includes it at t+2.
- Last pair accepted at tN: DRAIN occupies tN..tN+2 and `done` is high in the cycle after edge tN+2, with the final `acc_out`. `busy` falls at tN+3.
- Throughput is 1 pair per cycle. Minimum start-to-start spacing is `len`+4 cycles.

## Test plan

- **Unsigned dot product:** `signed_mode`=0, `len`=4, pairs (1,2),(3,4),(5,6),(7,8) on consecutive cycles. Expect `acc_out`=100, `done` 2 cycles after the last accept, `ovf`=0.
- **Signed dot product:** `len`=3, pairs (-1,127),(-128,-128),(5,-3). Expect `acc_out`=16242 (0x3F72), `ovf`=0.
- **Overflow, ACC_W=16, signed, pairs (-128,-128)×3:**
  - `SATURATE`=1: `acc_out` = 32767 (0x7FFF) and `ovf`=1 from the second product onward.
  - `SATURATE`=0: final `acc_out` = 0xC000 (-16384) and `ovf`=1.
- **Handshake:** `len`=3 with `in_valid` low on alternate cycles. Expect:
  - only accepted pairs appear on `a_out`/`b_out`, with exactly 3 `fwd_valid` pulses;
  - `start` pulsed during RUN is ignored;
  - the result matches the gap-free run.
- **Zero length:** `start` with `len`=0. Expect `done` in the next cycle, `acc_out`=0, `in_ready` never high.
- **Reset mid-operation:** drive `reset`=0 after 2 of 4 pairs are accepted. Expect all outputs 0, IDLE state, and no `done`. A subsequent `start` with `len`=1 and pair (9,9) gives 81.

Source files
------------

// File: rtl/mac_dot_unit.sv
// Pipelined multiply-accumulate PE: one dot product of `len` operand pairs per start,
// with operand forwarding for systolic chaining and optional saturating accumulation.
module mac_dot_unit #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 32,
  parameter int LEN_W    = 8,
  parameter bit SATURATE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              signed_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              fwd_valid,
  output logic [ACC_W-1:0]  acc_out,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int PROD_W = 2 * DATA_W;
  localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] UMAX = '1;

  state_t              state_reg, state_next;
  logic [LEN_W-1:0]    cnt_reg;
  logic                drain_reg;
  logic                sm_reg;
  logic [DATA_W-1:0]   a_reg, b_reg;
  logic                v1_reg, v2_reg;
  logic [PROD_W-1:0]   prod_reg;
  logic [ACC_W-1:0]    acc_reg;
  logic                ovf_reg;

  logic                accept;
  logic [PROD_W-1:0]   a_ext, b_ext;
  logic [ACC_W-1:0]    prod_ext;
  logic [ACC_W:0]      acc_x, prod_x, sum;
  logic                ovf_now;
  logic [ACC_W-1:0]    acc_next;

  assign in_ready  = (state_reg == RUN);
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign accept    = in_valid && in_ready;
  assign a_out     = a_reg;
  assign b_out     = b_reg;
  assign fwd_valid = v1_reg;
  assign acc_out   = acc_reg;
  assign ovf       = ovf_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = (len == '0) ? DONE : RUN;
      RUN:     if (accept && cnt_reg == LEN_W'(1)) state_next = DRAIN;
      DRAIN:   if (drain_reg) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Extending to the full product width makes one truncated multiply correct for both modes.
  assign a_ext = sm_reg ? {{DATA_W{a_reg[DATA_W-1]}}, a_reg} : {{DATA_W{1'b0}}, a_reg};
  assign b_ext = sm_reg ? {{DATA_W{b_reg[DATA_W-1]}}, b_reg} : {{DATA_W{1'b0}}, b_reg};

  generate
    if (ACC_W > PROD_W) begin : g_ext
      assign prod_ext = sm_reg ? {{(ACC_W-PROD_W){prod_reg[PROD_W-1]}}, prod_reg}
                               : {{(ACC_W-PROD_W){1'b0}}, prod_reg};
    end else begin : g_noext
      assign prod_ext = prod_reg;
    end
  endgenerate

  assign acc_x   = sm_reg ? {acc_reg[ACC_W-1], acc_reg} : {1'b0, acc_reg};
  assign prod_x  = sm_reg ? {prod_ext[ACC_W-1], prod_ext} : {1'b0, prod_ext};
  assign sum     = acc_x + prod_x;
  assign ovf_now = sm_reg ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];

  always_comb begin
    acc_next = sum[ACC_W-1:0];
    if (SATURATE && ovf_now) begin
      if (sm_reg) acc_next = sum[ACC_W] ? SMIN : SMAX;
      else        acc_next = UMAX;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      drain_reg <= 1'b0;
      sm_reg    <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      v1_reg    <= 1'b0;
      v2_reg    <= 1'b0;
      prod_reg  <= '0;
      acc_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      drain_reg <= (state_reg == DRAIN) && !drain_reg;
      v1_reg    <= accept;
      v2_reg    <= v1_reg;
      if (accept) begin
        a_reg   <= a_in;
        b_reg   <= b_in;
        cnt_reg <= cnt_reg - LEN_W'(1);
      end
      if (v1_reg) prod_reg <= a_ext * b_ext;
      if (v2_reg) begin
        acc_reg <= acc_next;
        if (ovf_now) ovf_reg <= 1'b1;
      end
      // A new dot product starts from a clean accumulator and overflow flag.
      if (state_reg == IDLE && start) begin
        cnt_reg <= len;
        sm_reg  <= signed_mode;
        acc_reg <= '0;
        ovf_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_dot_unit.sv
// Randomised and directed bench for mac_dot_unit: three instances (32-bit saturating,
// 16-bit saturating, 16-bit wrapping) share stimulus and are checked against a timeline model.
module tb_mac_dot_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        signed_mode = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  a_in = '0, b_in = '0;

  logic        ir0, ir1, ir2, bs0, bs1, bs2, dn0, dn1, dn2, fv0, fv1, fv2, ov0, ov1, ov2;
  logic [7:0]  ao0, ao1, ao2, bo0, bo1, bo2;
  logic [31:0] acc0;
  logic [15:0] acc1, acc2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mac_dot_unit #(.DATA_W(8), .ACC_W(32), .LEN_W(8), .SATURATE(1)) u0 (
    .clk(clk), .reset(reset), .start(start), .len(len), .signed_mode(signed_mode),
    .in_valid(in_valid), .in_ready(ir0), .a_in(a_in), .b_in(b_in), .a_out(ao0), .b_out(bo0),
    .fwd_valid(fv0), .acc_out(acc0), .busy(bs0), .done(dn0), .ovf(ov0));
  mac_dot_unit #(.DATA_W(8), .ACC_W(16), .LEN_W(8), .SATURATE(1)) u1 (
    .clk(clk), .reset(reset), .start(start), .len(len), .signed_mode(signed_mode),
    .in_valid(in_valid), .in_ready(ir1), .a_in(a_in), .b_in(b_in), .a_out(ao1), .b_out(bo1),
    .fwd_valid(fv1), .acc_out(acc1), .busy(bs1), .done(dn1), .ovf(ov1));
  mac_dot_unit #(.DATA_W(8), .ACC_W(16), .LEN_W(8), .SATURATE(0)) u2 (
    .clk(clk), .reset(reset), .start(start), .len(len), .signed_mode(signed_mode),
    .in_valid(in_valid), .in_ready(ir2), .a_in(a_in), .b_in(b_in), .a_out(ao2), .b_out(bo2),
    .fwd_valid(fv2), .acc_out(acc2), .busy(bs2), .done(dn2), .ovf(ov2));

  // Timeline model: a job is its start edge, length and the edges at which pairs were accepted.
  bit     model_on = 0;
  int     edge_n = 0;
  bit     job_active = 0;
  int     e0 = 0, job_len = 0, n_acc = 0, t_last = 0, last_acc = -10;
  bit     job_sm = 0;
  longint prod_q[$];
  int     prod_t[$];
  logic [7:0] exp_a = '0, exp_b = '0;
  int     fwd_cnt = 0;
  bit     ready_seen = 0;

  function automatic bit m_busy();
    if (!job_active) return 1'b0;
    if (job_len == 0) return edge_n == e0;
    return (n_acc < job_len) || (edge_n < t_last + 3);
  endfunction

  function automatic bit m_ready();
    return job_active && job_len > 0 && n_acc < job_len;
  endfunction

  function automatic bit m_done();
    if (!job_active) return 1'b0;
    if (job_len == 0) return edge_n == e0;
    return n_acc == job_len && edge_n == t_last + 2;
  endfunction

  // Products count once two edges have passed since their accept.
  function automatic void m_acc(input int w, input bit sat, output longint acc, output bit ov);
    longint mx, mn, s, span;
    acc = 0;
    ov  = 0;
    span = longint'(1) << w;
    mx = job_sm ? (span / 2 - 1) : (span - 1);
    mn = job_sm ? -(span / 2) : 0;
    if (job_active) begin
      for (int i = 0; i < prod_q.size(); i++) begin
        if (prod_t[i] + 2 <= edge_n) begin
          s = acc + prod_q[i];
          if (s > mx || s < mn) begin
            ov = 1;
            if (sat) s = (s > mx) ? mx : mn;
            else begin
              s = s & (span - 1);
              if (job_sm && s > mx) s = s - span;
            end
          end
          acc = s;
        end
      end
    end
    acc = acc & (span - 1);
  endfunction

  always @(posedge clk) begin
    bit pre_ready, pre_busy;
    pre_ready = m_ready();
    pre_busy  = m_busy();
    edge_n++;
    if (!reset) begin
      model_on = 1;
      job_active = 0;
      prod_q.delete();
      prod_t.delete();
      exp_a = '0;
      exp_b = '0;
      last_acc = -10;
    end else if (in_valid && pre_ready) begin
      n_acc++;
      t_last = edge_n;
      last_acc = edge_n;
      exp_a = a_in;
      exp_b = b_in;
      prod_q.push_back(job_sm ? longint'($signed(a_in)) * longint'($signed(b_in))
                              : longint'(a_in) * longint'(b_in));
      prod_t.push_back(edge_n);
    end else if (start && !pre_busy) begin
      job_active = 1;
      e0 = edge_n;
      job_len = int'(len);
      job_sm = signed_mode;
      n_acc = 0;
      prod_q.delete();
      prod_t.delete();
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, req, edge_n);
    end
  endtask

  task automatic cmp_dut(input int k, input int w, input bit sat, input logic ir, input logic bs,
                         input logic dn, input logic fv, input logic [7:0] ao, input logic [7:0] bo,
                         input logic [31:0] acc, input logic ov);
    longint ea;
    bit eo;
    m_acc(w, sat, ea, eo);
    chk($sformatf("d%0d.in_ready", k), 64'(ir), 64'(m_ready()));
    chk($sformatf("d%0d.busy", k), 64'(bs), 64'(m_busy()));
    chk($sformatf("d%0d.done", k), 64'(dn), 64'(m_done()));
    chk($sformatf("d%0d.fwd_valid", k), 64'(fv), 64'(last_acc == edge_n));
    chk($sformatf("d%0d.a_out", k), 64'(ao), 64'(exp_a));
    chk($sformatf("d%0d.b_out", k), 64'(bo), 64'(exp_b));
    chk($sformatf("d%0d.acc_out", k), 64'(acc), 64'(ea));
    chk($sformatf("d%0d.ovf", k), 64'(ov), 64'(eo));
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      cmp_dut(0, 32, 1'b1, ir0, bs0, dn0, fv0, ao0, bo0, acc0, ov0);
      cmp_dut(1, 16, 1'b1, ir1, bs1, dn1, fv1, ao1, bo1, {16'h0, acc1}, ov1);
      cmp_dut(2, 16, 1'b0, ir2, bs2, dn2, fv2, ao2, bo2, {16'h0, acc2}, ov2);
      if (fv0) fwd_cnt++;
      if (ir0) ready_seen = 1;
    end
  end

  int pa[16];
  int pb[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // gap_mode: 0 back-to-back, 1 one bubble before each pair, 2 random bubbles.
  task automatic job(input int l, input bit s, input int gap_mode);
    int n;
    start = 1'b1;
    len = 8'(l);
    signed_mode = s;
    tick();
    start = 1'b0;
    for (int i = 0; i < l; i++) begin
      n = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < n; g++) begin
        in_valid = 1'b0;
        a_in = 8'($urandom);
        b_in = 8'($urandom);
        if (i == 1) begin
          start = 1'b1;
          len = 8'($urandom_range(0, 5));
          signed_mode = ~s;
        end
        tick();
        start = 1'b0;
      end
      in_valid = 1'b1;
      a_in = 8'(pa[i]);
      b_in = 8'(pb[i]);
      tick();
      in_valid = 1'b0;
    end
    for (int k = 0; k < 20 && m_busy(); k++) tick();
    if (m_busy()) begin
      n_cmp++;
      n_bad++;
      $display("FAIL job_timeout actual=busy required=idle (edge %0d)", edge_n);
    end
    $display("job len=%0d signed=%0d acc32=%0h acc16s=%0h acc16w=%0h ovf=%0d%0d%0d",
             l, s, acc0, acc1, acc2, ov0, ov1, ov2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();

    pa[0:3] = '{1, 3, 5, 7};
    pb[0:3] = '{2, 4, 6, 8};
    job(4, 1'b0, 0);
    chk("unsigned.acc32", 64'(acc0), 64'd100);
    chk("unsigned.acc16", 64'(acc2), 64'd100);
    chk("unsigned.ovf", 64'(ov0), 64'd0);

    pa[0:2] = '{-1, -128, 5};
    pb[0:2] = '{127, -128, -3};
    job(3, 1'b1, 0);
    chk("signed.acc32", 64'(acc0), 64'h3F72);
    chk("signed.ovf", 64'(ov0), 64'd0);

    pa[0:2] = '{-128, -128, -128};
    pb[0:2] = '{-128, -128, -128};
    job(3, 1'b1, 0);
    chk("ovf.acc32", 64'(acc0), 64'd49152);
    chk("ovf.sat_acc", 64'(acc1), 64'h7FFF);
    chk("ovf.sat_flag", 64'(ov1), 64'd1);
    chk("ovf.wrap_acc", 64'(acc2), 64'hC000);
    chk("ovf.wrap_flag", 64'(ov2), 64'd1);

    pa[0:2] = '{-1, -128, 5};
    pb[0:2] = '{127, -128, -3};
    fwd_cnt = 0;
    job(3, 1'b1, 1);
    chk("handshake.acc32", 64'(acc0), 64'h3F72);
    chk("handshake.fwd_pulses", 64'(fwd_cnt), 64'd3);

    ready_seen = 0;
    job(0, 1'b0, 0);
    chk("zero.acc32", 64'(acc0), 64'd0);
    chk("zero.ready_seen", 64'(ready_seen), 64'd0);

    start = 1'b1;
    len = 8'd4;
    signed_mode = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      a_in = 8'(10 + i);
      b_in = 8'(20 + i);
      tick();
    end
    in_valid = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("reset.acc32", 64'(acc0), 64'd0);
    chk("reset.busy", 64'(bs0), 64'd0);
    chk("reset.a_out", 64'(ao0), 64'd0);
    $display("reset applied mid-run after 2 of 4 pairs");
    tick();
    pa[0] = 9;
    pb[0] = 9;
    job(1, 1'b0, 0);
    chk("after_reset.acc32", 64'(acc0), 64'd81);

    for (int j = 0; j < 40; j++) begin
      int l;
      l = int'($urandom_range(0, 10));
      for (int i = 0; i < l; i++) begin
        pa[i] = int'($urandom_range(0, 255));
        pb[i] = int'($urandom_range(0, 255));
      end
      job(l, 1'(($urandom)), 2);
      repeat ($urandom_range(0, 2)) tick();
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
